regfile_mp: RTL and testbench

Parametrised multi-port integer register file with an integrated write-pending scoreboard, for the core's decode/writeback boundary. It serves NRP combinational read ports and NWP synchronous write ports, with optional write-to-read bypass and a hardwired zero register. Per-register busy bits are set on instruction issue and cleared on writeback, giving decode a hazard indication per read port and a WAW issue stall.

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_mp_if.sv | 41 ++++
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths, helper functions and typedefs for the
//                multi-port register file and its scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Address width; never below one bit so port vectors stay legal.
    function automatic int addr_width(input int nreg);
        return (nreg <= 2) ? 1 : $clog2(nreg);
    endfunction

    // Width able to hold a count from 0 to nreg inclusive.
    function automatic int count_width(input int nreg);
        return $clog2(nreg + 1);
    endfunction

    localparam int AW_DEF = addr_width(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_if
//  Description : Read, write and issue bundle between decode/writeback and
//                the register file. master = core side, slave = regfile.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP  = 2,
    parameter int NWP  = 2
);
    localparam int AW = addr_width(NREG);
    localparam int CW = count_width(NREG);

    logic [NRP-1:0][AW-1:0]   i_raddr;
    logic [NRP-1:0][XLEN-1:0] o_rdata;
    logic [NRP-1:0]           o_rbusy;
    logic [NWP-1:0]           i_we;
    logic [NWP-1:0][AW-1:0]   i_waddr;
    logic [NWP-1:0][XLEN-1:0] i_wdata;
    logic                     i_issue_valid;
    logic [AW-1:0]            i_issue_rd;
    logic                     o_issue_ready;
    logic [CW-1:0]            o_pending;

    modport master (
        output i_raddr, i_we, i_waddr, i_wdata, i_issue_valid, i_issue_rd,
        input  o_rdata, o_rbusy, o_issue_ready, o_pending
    );

    modport slave (
        input  i_raddr, i_we, i_waddr, i_wdata, i_issue_valid, i_issue_rd,
        output o_rdata, o_rbusy, o_issue_ready, o_pending
    );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register write-pending bits. Issue sets, writeback
//                clears, set beats clear; registered popcount of busy bits.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG     = NREG_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = addr_width(NREG),
    localparam int CW       = count_width(NREG)
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    input  wire logic            i_issue_valid,
    input  wire logic [AW-1:0]   i_issue_rd,
    input  wire logic [NREG-1:0] i_clr_vec,
    output logic      [NREG-1:0] o_busy,
    output logic                 o_issue_ready,
    output logic      [CW-1:0]   o_pending
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [NREG-1:0] w_set_vec;
    logic [CW-1:0]   r_pending;
    logic [CW-1:0]   w_popcnt;
    logic            w_rd_zero;
    logic            w_accept;

    // Issue acceptance looks only at registered busy state, so a same-cycle
    // writeback of rd never lets a WAW issue slip through.
    always_comb begin
        w_rd_zero     = (ZERO_REG != 0) && (i_issue_rd == '0);
        o_issue_ready = w_rd_zero || !r_busy[i_issue_rd];
        w_accept      = i_issue_valid && o_issue_ready;
        w_set_vec     = '0;
        if (w_accept && !w_rd_zero) begin
            w_set_vec[i_issue_rd] = 1'b1;
        end
    end

    // Next busy vector (set applied after clear) and its population count.
    always_comb begin
        w_busy_nxt = (r_busy & ~i_clr_vec) | w_set_vec;
        w_popcnt   = '0;
        for (int i = 0; i < NREG; i++) begin
            w_popcnt = w_popcnt + CW'(w_busy_nxt[i]);
        end
    end

    // Busy bits and pending count, cleared asynchronously on reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_pending <= w_popcnt;
        end
    end

    assign o_busy    = r_busy;
    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port integer register file with write arbitration,
//                optional write-to-read bypass, hardwired zero register and
//                an integrated write-pending scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREG     = NREG_DEF,
    parameter  int NRP      = 2,
    parameter  int NWP      = 2,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = addr_width(NREG),
    localparam int CW       = count_width(NREG)
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst,
    regfile_mp_if.slave bus
);

    logic [XLEN-1:0]          r_mem [NREG];
    logic [NWP-1:0]           w_wr_ok;
    logic [NREG-1:0]          w_clr_vec;
    logic [NREG-1:0]          w_busy;
    logic [NRP-1:0][XLEN-1:0] w_rdata;
    logic [NRP-1:0]           w_rbusy;
    logic                     w_issue_ready;
    logic [CW-1:0]            w_pending;

    // Writes that actually update storage (x0 stays zero when hardwired).
    always_comb begin
        for (int p = 0; p < NWP; p++) begin
            w_wr_ok[p] = bus.i_we[p] &&
                         !((ZERO_REG != 0) && (bus.i_waddr[p] == '0));
        end
    end

    // Storage array; ports applied in index order so the highest one wins.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWP; p++) begin
                if (w_wr_ok[p]) begin
                    r_mem[bus.i_waddr[p]] <= bus.i_wdata[p];
                end
            end
        end
    end

    // Any enabled write port retires the pending bit of its destination.
    always_comb begin
        w_clr_vec = '0;
        for (int p = 0; p < NWP; p++) begin
            if (bus.i_we[p]) begin
                w_clr_vec[bus.i_waddr[p]] = 1'b1;
            end
        end
    end

    regfile_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_issue_valid (bus.i_issue_valid),
        .i_issue_rd    (bus.i_issue_rd),
        .i_clr_vec     (w_clr_vec),
        .o_busy        (w_busy),
        .o_issue_ready (w_issue_ready),
        .o_pending     (w_pending)
    );

    // Read muxes: array, then bypass from the highest matching write port,
    // then the zero-register override.
    always_comb begin
        for (int r = 0; r < NRP; r++) begin
            w_rdata[r] = r_mem[bus.i_raddr[r]];
            w_rbusy[r] = w_busy[bus.i_raddr[r]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWP; p++) begin
                    if (bus.i_we[p] && (bus.i_waddr[p] == bus.i_raddr[r])) begin
                        w_rdata[r] = bus.i_wdata[p];
                        w_rbusy[r] = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (bus.i_raddr[r] == '0)) begin
                w_rdata[r] = '0;
                w_rbusy[r] = 1'b0;
            end
        end
    end

    assign bus.o_rdata       = w_rdata;
    assign bus.o_rbusy       = w_rbusy;
    assign bus.o_issue_ready = w_issue_ready;
    assign bus.o_pending     = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp: a 32x32 2R/2W bypassed
//                instance (A) and a 16-entry 3R/1W non-bypassed instance (B).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREG(32), .NRP(2), .NWP(2)) bus_a ();
    regfile_mp_if #(.XLEN(32), .NREG(16), .NRP(3), .NWP(1)) bus_b ();

    regfile_mp #(.XLEN(32), .NREG(32), .NRP(2), .NWP(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .i_clk (clk), .i_rst (rst_n), .bus (bus_a.slave)
    );
    regfile_mp #(.XLEN(32), .NREG(16), .NRP(3), .NWP(1), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .i_clk (clk), .i_rst (rst_n), .bus (bus_b.slave)
    );

    // Reference state: architectural contents and pending-write set.
    reg_data_t   ma_mem [32];
    logic [31:0] ma_busy;
    reg_data_t   mb_mem [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ma_mem[i] = '0;
        for (int i = 0; i < 16; i++) mb_mem[i] = '0;
        ma_busy = '0;
    endtask

    // What a reader of address a sees on A this cycle.
    function automatic reg_data_t exp_rdata_a(input logic [4:0] a);
        reg_data_t v;
        v = ma_mem[a];
        for (int p = 0; p < 2; p++)
            if (bus_a.i_we[p] && bus_a.i_waddr[p] == a) v = bus_a.i_wdata[p];
        return (a == 0) ? '0 : v;
    endfunction

    function automatic logic exp_rbusy_a(input logic [4:0] a);
        logic b;
        b = ma_busy[a];
        for (int p = 0; p < 2; p++)
            if (bus_a.i_we[p] && bus_a.i_waddr[p] == a) b = 1'b0;
        return (a == 0) ? 1'b0 : b;
    endfunction

    function automatic logic exp_ready_a();
        return (bus_a.i_issue_rd == 0) || !ma_busy[bus_a.i_issue_rd];
    endfunction

    task automatic check_a();
        for (int r = 0; r < 2; r++) begin
            chk($sformatf("a_rdata%0d", r), 64'(bus_a.o_rdata[r]), 64'(exp_rdata_a(bus_a.i_raddr[r])));
            chk($sformatf("a_rbusy%0d", r), 64'(bus_a.o_rbusy[r]), 64'(exp_rbusy_a(bus_a.i_raddr[r])));
        end
        chk("a_issue_ready", 64'(bus_a.o_issue_ready), 64'(exp_ready_a()));
        chk("a_pending", 64'(bus_a.o_pending), 64'($countones(ma_busy)));
    endtask

    task automatic check_b();
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("b_rdata%0d", r), 64'(bus_b.o_rdata[r]),
                (bus_b.i_raddr[r] == 0) ? 64'd0 : 64'(mb_mem[bus_b.i_raddr[r]]));
        end
        chk("b_pending", 64'(bus_b.o_pending), 64'd0);
    endtask

    // Advance the reference by one clock edge using the inputs now applied.
    task automatic commit();
        logic acc;
        acc = bus_a.i_issue_valid && exp_ready_a();
        for (int p = 0; p < 2; p++) begin
            if (bus_a.i_we[p]) begin
                if (bus_a.i_waddr[p] != 0) ma_mem[bus_a.i_waddr[p]] = bus_a.i_wdata[p];
                ma_busy[bus_a.i_waddr[p]] = 1'b0;
            end
        end
        if (acc && bus_a.i_issue_rd != 0) ma_busy[bus_a.i_issue_rd] = 1'b1;
        if (bus_b.i_we[0] && bus_b.i_waddr[0] != 0) mb_mem[bus_b.i_waddr[0]] = bus_b.i_wdata[0];
    endtask

    // Inputs are applied just after a rising edge; check mid-cycle, then clock.
    task automatic cycle();
        @(negedge clk);
        check_a();
        check_b();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic idle();
        bus_a.i_we = '0; bus_a.i_waddr = '0; bus_a.i_wdata = '0;
        bus_a.i_issue_valid = 1'b0; bus_a.i_issue_rd = '0; bus_a.i_raddr = '0;
        bus_b.i_we = '0; bus_b.i_waddr = '0; bus_b.i_wdata = '0; bus_b.i_raddr = '0;
    endtask

    initial begin
        idle();
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_a();
        check_b();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Dual write collision on x5: higher port wins, bypassed same cycle.
        bus_a.i_we = 2'b11;
        bus_a.i_waddr[0] = 5'd5; bus_a.i_wdata[0] = 32'hAAAA_0001;
        bus_a.i_waddr[1] = 5'd5; bus_a.i_wdata[1] = 32'hBBBB_0002;
        bus_a.i_raddr[0] = 5'd5;
        @(negedge clk);
        chk("collision_bypass", 64'(bus_a.o_rdata[0]), 64'h0000_0000_BBBB_0002);
        @(posedge clk); commit(); #1;
        bus_a.i_we = '0;
        @(negedge clk);
        chk("collision_array", 64'(bus_a.o_rdata[0]), 64'h0000_0000_BBBB_0002);
        @(posedge clk); commit(); #1;

        // Zero register: write and issue to x0 have no visible effect.
        bus_a.i_we = 2'b01; bus_a.i_waddr[0] = 5'd0; bus_a.i_wdata[0] = 32'hDEAD_BEEF;
        bus_a.i_issue_valid = 1'b1; bus_a.i_issue_rd = 5'd0; bus_a.i_raddr[1] = 5'd0;
        cycle();
        bus_a.i_we = '0; bus_a.i_issue_valid = 1'b0;
        @(negedge clk);
        chk("x0_read", 64'(bus_a.o_rdata[1]), 64'd0);
        chk("x0_pending", 64'(bus_a.o_pending), 64'd0);
        chk("x0_rbusy", 64'(bus_a.o_rbusy[1]), 64'd0);
        @(posedge clk); commit(); #1;

        // Scoreboard flow on x7.
        bus_a.i_issue_valid = 1'b1; bus_a.i_issue_rd = 5'd7; bus_a.i_raddr[0] = 5'd7;
        cycle();
        @(negedge clk);
        chk("sb_rbusy7", 64'(bus_a.o_rbusy[0]), 64'd1);
        chk("sb_pending1", 64'(bus_a.o_pending), 64'd1);
        chk("sb_waw_stall", 64'(bus_a.o_issue_ready), 64'd0);
        @(posedge clk); commit(); #1;
        bus_a.i_issue_valid = 1'b0;
        bus_a.i_we = 2'b01; bus_a.i_waddr[0] = 5'd7; bus_a.i_wdata[0] = 32'h0000_1234;
        cycle();
        bus_a.i_we = '0;
        @(negedge clk);
        chk("sb_cleared7", 64'(bus_a.o_rbusy[0]), 64'd0);
        chk("sb_pending0", 64'(bus_a.o_pending), 64'd0);
        chk("sb_data7", 64'(bus_a.o_rdata[0]), 64'h1234);
        @(posedge clk); commit(); #1;

        // Set/clear race on x3, first with x3 busy, then with x3 idle.
        bus_a.i_issue_valid = 1'b1; bus_a.i_issue_rd = 5'd3; bus_a.i_raddr[0] = 5'd3;
        cycle();
        bus_a.i_we = 2'b10; bus_a.i_waddr[1] = 5'd3; bus_a.i_wdata[1] = 32'h0000_0033;
        @(negedge clk);
        chk("race_busy_ready", 64'(bus_a.o_issue_ready), 64'd0);
        @(posedge clk); commit(); #1;
        @(negedge clk);
        chk("race_busy_after", 64'(bus_a.o_rbusy[0]), 64'd0);
        chk("race_idle_ready", 64'(bus_a.o_issue_ready), 64'd1);
        @(posedge clk); commit(); #1;
        bus_a.i_we = '0; bus_a.i_issue_valid = 1'b0;
        @(negedge clk);
        chk("race_idle_after", 64'(bus_a.o_rbusy[0]), 64'd1);
        chk("race_idle_pending", 64'(bus_a.o_pending), 64'd1);
        @(posedge clk); commit(); #1;

        // Randomised traffic on A, confined to x0..x7 to provoke hazards.
        for (int n = 0; n < 300; n++) begin
            bus_a.i_we = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                bus_a.i_waddr[p] = 5'($urandom_range(0, 7));
                bus_a.i_wdata[p] = $urandom;
                bus_a.i_raddr[p] = 5'($urandom_range(0, 7));
            end
            bus_a.i_issue_valid = 1'($urandom_range(0, 1));
            bus_a.i_issue_rd = 5'($urandom_range(0, 7));
            cycle();
        end

        // Asynchronous reset in the middle of a cycle.
        bus_a.i_we = '0; bus_a.i_issue_valid = 1'b0;
        bus_a.i_raddr[0] = 5'd5; bus_a.i_raddr[1] = 5'd6; bus_a.i_issue_rd = 5'd3;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_a();
        chk("rst_rdata", 64'(bus_a.o_rdata[0]), 64'd0);
        chk("rst_ready", 64'(bus_a.o_issue_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();

        // Instance B: no bypass, x9 read during its own write shows old data.
        bus_b.i_we = 1'b1; bus_b.i_waddr[0] = 4'd9; bus_b.i_wdata[0] = 32'h1111_1111;
        cycle();
        bus_b.i_wdata[0] = 32'h2222_2222; bus_b.i_raddr[0] = 4'd9;
        @(negedge clk);
        chk("b_x9_old", 64'(bus_b.o_rdata[0]), 64'h1111_1111);
        @(posedge clk); commit(); #1;
        bus_b.i_we = 1'b0;
        @(negedge clk);
        chk("b_x9_new", 64'(bus_b.o_rdata[0]), 64'h2222_2222);
        @(posedge clk); commit(); #1;

        // Fill all 16 registers with random data, then read them back.
        for (int i = 0; i < 16; i++) begin
            bus_b.i_we = 1'b1; bus_b.i_waddr[0] = 4'(i); bus_b.i_wdata[0] = $urandom;
            bus_b.i_raddr[0] = 4'($urandom_range(0, 15));
            cycle();
        end
        bus_b.i_we = 1'b0;
        for (int i = 0; i < 16; i += 3) begin
            for (int r = 0; r < 3; r++) bus_b.i_raddr[r] = 4'((i + r) % 16);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
